// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide unit owning the HI/LO pair.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi_data,
  output logic [WIDTH-1:0] lo_data
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic { S_IDLE, S_RUN } state_e;
  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   opb_q, opb_d;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;     // product accumulator; low half is dividend/quotient

  logic               signed_op, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum, rem_shift;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_step, dq_step, quot, remd;
  logic [2*WIDTH-1:0] acc_step, prod;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opb_d     = opb_q;
    rem_d     = rem_q;
    acc_d     = acc_q;

    signed_op = (op == OP_MULT) || (op == OP_DIV);
    a_neg     = signed_op && a[WIDTH-1];
    b_neg     = signed_op && b[WIDTH-1];
    a_mag     = a_neg ? -a : a;
    b_mag     = b_neg ? -b : b;

    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    acc_step  = {mul_sum, acc_q[WIDTH-1:1]};
    prod      = neg_res_q ? -acc_step : acc_step;

    // Restoring step: the shifted partial remainder needs WIDTH+1 bits, but
    // after the conditional subtract it is always below the divisor.
    rem_shift = {rem_q, acc_q[WIDTH-1]};
    rem_ge    = rem_shift >= {1'b0, opb_q};
    rem_step  = rem_ge ? WIDTH'(rem_shift - {1'b0, opb_q}) : rem_shift[WIDTH-1:0];
    dq_step   = {acc_q[WIDTH-2:0], rem_ge};
    quot      = neg_res_q ? -dq_step : dq_step;
    remd      = neg_rem_q ? -rem_step : rem_step;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end else if (op[2] == 1'b0) begin
            is_div_d  = op[1];
            neg_res_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            dz_d      = op[1] && (b == '0);
            cnt_d     = '0;
            state_d   = S_RUN;
            if (op[1]) begin
              opb_d = b_mag;
              acc_d = {{WIDTH{1'b0}}, a_mag};
              rem_d = '0;
            end else begin
              opb_d = a_mag;
              acc_d = {{WIDTH{1'b0}}, b_mag};
            end
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (is_div_q) begin
          rem_d = rem_step;
          acc_d = {acc_q[2*WIDTH-1:WIDTH], dq_step};
        end else begin
          acc_d = acc_step;
        end
        if (cnt_q == LAST_ITER) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod;
          end else if (!dz_q) begin
            lo_d = quot;
            hi_d = remd;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      rem_q     <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opb_q     <= opb_d;
      rem_q     <= rem_d;
      acc_q     <= acc_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = done_q;
  assign div_by_zero = dz_q;
  assign hi_data     = hi_q;
  assign lo_data     = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at WIDTH=32: expected HI/LO/div_by_zero
// are queued when an op is launched and compared when done pulses.
module tb_muldiv_unit;

  localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3,
                         MTHI = 3'd4, MTLO = 3'd5;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi_data, lo_data;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] sb_hi, sb_lo;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .op(op), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi_data(hi_data), .lo_data(lo_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: returns {div_by_zero, HI, LO}.
  function automatic logic [64:0] model_op(input logic [2:0] o, input logic [31:0] x, y,
                                           input logic [31:0] cur_hi, cur_lo);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      MULT:  begin q = sx * sy; return {1'b0, q}; end
      MULTU: begin p = {32'd0, x} * {32'd0, y}; return {1'b0, p}; end
      DIV: begin
        if (y == 0) return {1'b1, cur_hi, cur_lo};
        q = sx / sy; r = sx % sy;
        return {1'b0, r[31:0], q[31:0]};
      end
      default: begin
        if (y == 0) return {1'b1, cur_hi, cur_lo};
        return {1'b0, x % y, x / y};
      end
    endcase
  endfunction

  task automatic push_exp(input logic [31:0] hi, lo, input logic dz, input string name);
    exp_t e;
    e.hi = hi; e.lo = lo; e.dz = dz; e.name = name;
    exp_q.push_back(e);
    sb_hi = hi; sb_lo = lo;
  endtask

  // Launches an op at the current negedge and returns at the negedge where
  // done is seen. Scrambles a/b during RUN and optionally pokes an MTHI.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, y, input int poke_at,
                        output int busy_cyc, output bit timed_out, output bit stable);
    logic [31:0] h0, l0;
    h0 = hi_data; l0 = lo_data;
    op = o; a = x; b = y; start = 1'b1;
    busy_cyc = 0; timed_out = 1'b1; stable = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 1) begin a = ~x; b = y ^ 32'h5A5A_5A5A; end
      if (k == poke_at) begin
        start = 1'b1; op = MTHI; a = 32'hDEAD_0000; b = 32'h0000_BEEF;
      end
      if (done) begin timed_out = 1'b0; break; end
      if (busy) busy_cyc++;
      if (hi_data !== h0 || lo_data !== l0) stable = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      n_bad++; $display("FAIL reset_flags: got %b want 000", {busy, done, div_by_zero});
    end
    n_cmp++;
    if ({hi_data, lo_data} !== 64'd0) begin
      n_bad++; $display("FAIL reset_hilo: got %h want 0", {hi_data, lo_data});
    end
    rst = 1'b0;
    sb_hi = '0; sb_lo = '0;
    @(negedge clk);
  endtask

  task automatic test_mult;
    int bc; bit to, st; exp_t e;
    push_exp(32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_neg3x7");
    run_op(MULT, 32'hFFFF_FFFD, 32'd7, 0, bc, to, st);
    e = exp_q.pop_front();
    n_cmp++;
    if ({div_by_zero, hi_data, lo_data} !== {e.dz, e.hi, e.lo}) begin
      n_bad++; $display("FAIL %s: got %b/%h/%h want %b/%h/%h", e.name,
                        div_by_zero, hi_data, lo_data, e.dz, e.hi, e.lo);
    end
    n_cmp++;
    if (bc !== 32 || to !== 1'b0) begin
      n_bad++; $display("FAIL mult_busy_cycles: got %0d (timeout %0d) want 32", bc, to);
    end
    n_cmp++;
    if ({st, busy} !== 2'b10) begin
      n_bad++; $display("FAIL mult_hilo_hold_busy_low: got stable=%0d busy=%0d want 1/0", st, busy);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++; $display("FAIL done_one_cycle: got done=%0d want 0", done);
    end

    push_exp(32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, bc, to, st);
    e = exp_q.pop_front();
    n_cmp++;
    if ({div_by_zero, hi_data, lo_data} !== {e.dz, e.hi, e.lo} || to) begin
      n_bad++; $display("FAIL %s: got %b/%h/%h want %b/%h/%h", e.name,
                        div_by_zero, hi_data, lo_data, e.dz, e.hi, e.lo);
    end

    push_exp(32'h4000_0000, 32'h0000_0000, 1'b0, "mult_minmin");
    run_op(MULT, 32'h8000_0000, 32'h8000_0000, 0, bc, to, st);
    e = exp_q.pop_front();
    n_cmp++;
    if ({div_by_zero, hi_data, lo_data} !== {e.dz, e.hi, e.lo} || to) begin
      n_bad++; $display("FAIL %s: got %b/%h/%h want %b/%h/%h", e.name,
                        div_by_zero, hi_data, lo_data, e.dz, e.hi, e.lo);
    end
    @(negedge clk);
  endtask

  task automatic test_div;
    int bc; bit to, st; exp_t e;
    logic [2:0]  ops[4] = '{DIV, DIVU, DIV, DIV};
    logic [31:0] xs[4]  = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd7};
    logic [31:0] ys[4]  = '{32'd2, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [31:0] eh[4]  = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'd1};
    logic [31:0] el[4]  = '{32'hFFFF_FFFD, 32'd3, 32'h8000_0000, 32'hFFFF_FFFD};
    for (int i = 0; i < 4; i++) begin
      push_exp(eh[i], el[i], 1'b0, $sformatf("div_case%0d", i));
      run_op(ops[i], xs[i], ys[i], 0, bc, to, st);
      e = exp_q.pop_front();
      n_cmp++;
      if ({div_by_zero, hi_data, lo_data} !== {e.dz, e.hi, e.lo} || bc != 32 || to) begin
        n_bad++; $display("FAIL %s: got %b/%h/%h cyc=%0d want %b/%h/%h cyc=32", e.name,
                          div_by_zero, hi_data, lo_data, bc, e.dz, e.hi, e.lo);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_moves_and_dz;
    int bc; bit to, st; exp_t e;
    op = MTHI; a = 32'h11; b = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({hi_data, busy, done} !== {32'h11, 2'b00}) begin
      n_bad++; $display("FAIL mthi: got hi=%h busy=%0d done=%0d want 11/0/0", hi_data, busy, done);
    end
    op = MTLO; a = 32'h22; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({hi_data, lo_data, busy} !== {32'h11, 32'h22, 1'b0}) begin
      n_bad++; $display("FAIL mtlo: got %h/%h busy=%0d want 11/22/0", hi_data, lo_data, busy);
    end
    op = 3'b110; a = 32'h99; start = 1'b1;
    @(negedge clk);
    op = 3'b111;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({hi_data, lo_data, busy, done} !== {32'h11, 32'h22, 2'b00}) begin
      n_bad++; $display("FAIL noop_ops: got %h/%h busy=%0d done=%0d want 11/22/0/0",
                        hi_data, lo_data, busy, done);
    end
    sb_hi = 32'h11; sb_lo = 32'h22;

    push_exp(32'h11, 32'h22, 1'b1, "div_by_zero");
    run_op(DIV, 32'd5, 32'd0, 0, bc, to, st);
    e = exp_q.pop_front();
    n_cmp++;
    if ({div_by_zero, hi_data, lo_data} !== {e.dz, e.hi, e.lo} || bc != 32 || to) begin
      n_bad++; $display("FAIL %s: got %b/%h/%h cyc=%0d want %b/%h/%h cyc=32", e.name,
                        div_by_zero, hi_data, lo_data, bc, e.dz, e.hi, e.lo);
    end
    @(negedge clk);
    push_exp(32'd0, 32'd6, 1'b0, "mult_clears_dz");
    run_op(MULT, 32'd2, 32'd3, 0, bc, to, st);
    e = exp_q.pop_front();
    n_cmp++;
    if ({div_by_zero, hi_data, lo_data} !== {e.dz, e.hi, e.lo} || to) begin
      n_bad++; $display("FAIL %s: got %b/%h/%h want %b/%h/%h", e.name,
                        div_by_zero, hi_data, lo_data, e.dz, e.hi, e.lo);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    int bc; bit to, st; exp_t e; logic [64:0] m;
    m = model_op(MULTU, 32'h1234_5678, 32'd9, sb_hi, sb_lo);
    push_exp(m[63:32], m[31:0], m[64], "multu_poked");
    run_op(MULTU, 32'h1234_5678, 32'd9, 5, bc, to, st);
    e = exp_q.pop_front();
    n_cmp++;
    if ({div_by_zero, hi_data, lo_data} !== {e.dz, e.hi, e.lo} || bc != 32 || to) begin
      n_bad++; $display("FAIL %s: got %b/%h/%h cyc=%0d want %b/%h/%h cyc=32", e.name,
                        div_by_zero, hi_data, lo_data, bc, e.dz, e.hi, e.lo);
    end
    // Launched in the done cycle: must be accepted without an idle gap.
    push_exp(32'd2, 32'd14, 1'b0, "divu_in_done_cycle");
    run_op(DIVU, 32'd100, 32'd7, 0, bc, to, st);
    e = exp_q.pop_front();
    n_cmp++;
    if ({div_by_zero, hi_data, lo_data} !== {e.dz, e.hi, e.lo} || bc != 32 || to) begin
      n_bad++; $display("FAIL %s: got %b/%h/%h cyc=%0d want %b/%h/%h cyc=32", e.name,
                        div_by_zero, hi_data, lo_data, bc, e.dz, e.hi, e.lo);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run;
    int bc; bit to, st, quiet; exp_t e;
    op = DIVU; a = 32'd1000; b = 32'd7; start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, div_by_zero, hi_data, lo_data} !== 67'd0) begin
      n_bad++; $display("FAIL async_reset_mid_run: got busy=%0d done=%0d hi=%h lo=%h want all 0",
                        busy, done, hi_data, lo_data);
    end
    @(negedge clk);
    rst = 1'b0;
    sb_hi = '0; sb_lo = '0;
    quiet = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done || busy || hi_data != 0 || lo_data != 0) quiet = 1'b0;
    end
    n_cmp++;
    if (quiet !== 1'b1) begin
      n_bad++; $display("FAIL aborted_no_commit: got activity after reset want none");
    end
    push_exp(32'd0, 32'd42, 1'b0, "mult_after_reset");
    run_op(MULT, 32'd6, 32'd7, 0, bc, to, st);
    e = exp_q.pop_front();
    n_cmp++;
    if ({div_by_zero, hi_data, lo_data} !== {e.dz, e.hi, e.lo} || to) begin
      n_bad++; $display("FAIL %s: got %b/%h/%h want %b/%h/%h", e.name,
                        div_by_zero, hi_data, lo_data, e.dz, e.hi, e.lo);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int bc; bit to, st; exp_t e; logic [64:0] m;
    logic [2:0] o; logic [31:0] x, y;
    for (int i = 0; i < 8; i++) begin
      o = 3'($urandom_range(0, 3));
      x = $urandom;
      y = (i == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
      m = model_op(o, x, y, sb_hi, sb_lo);
      push_exp(m[63:32], m[31:0], m[64], $sformatf("rand%0d_op%0d", i, o));
      run_op(o, x, y, 0, bc, to, st);
      e = exp_q.pop_front();
      n_cmp++;
      if ({div_by_zero, hi_data, lo_data} !== {e.dz, e.hi, e.lo} || bc != 32 || to) begin
        n_bad++; $display("FAIL %s a=%h b=%h: got %b/%h/%h cyc=%0d want %b/%h/%h cyc=32", e.name,
                          x, y, div_by_zero, hi_data, lo_data, bc, e.dz, e.hi, e.lo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_moves_and_dz();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
